aes_shift_rows_pipe: RTL and testbench
======================================

// Module: aes_shift_rows_pipe
// PURPOSE
//  Parametrised ShiftRows / InvShiftRows stage for the AES/Rijndael round pipeline.
//  Each beat selects encrypt or decrypt mode and carries a sideband tag.
//  Block width is generalised to Rijndael Nb = 4, 6 or 8 columns.
//  Beats pass through a 2-entry elastic output buffer with valid/ready backpressure,
//  so the stage can sit between SubBytes and MixColumns in a stallable pipeline.
// PARAMETERS
//  NB         4    number of state columns; legal values 4, 6, 8 (others: elaboration error)
//  DATA_WIDTH 32*NB  state width in bits (derived, not overridable)
//  TAG_WIDTH  4    width of the sideband tag carried with each beat (>=1)
// PORTS
//  clk        in   1           clock, rising edge
//  rst        in   1           reset, asynchronous, active-low
//  in_valid   in   1           upstream beat valid
//  in_ready   out  1           stage can accept a beat this cycle
//  in_decrypt in   1           0 = ShiftRows, 1 = InvShiftRows (sampled with the beat)
//  in_bypass  in   1           1 = pass data unpermuted (mode ignored)
//  in_data    in   DATA_WIDTH  state in; byte k = [DATA_WIDTH-1-8k -: 8], k = 4*col + row
//  in_tag     in   TAG_WIDTH   sideband tag, travels with data unchanged
//  out_valid  out  1           output beat valid
//  out_ready  in   1           downstream accepts the beat
//  out_data   out  DATA_WIDTH  permuted state
//  out_tag    out  TAG_WIDTH   tag of the beat on out_data
//  occupancy  out  2           number of buffered beats (0..2)
// BEHAVIOUR
//  - Row shift s(r): NB=4/6 -> 0,1,2,3; NB=8 -> 0,1,3,4.
//  - Encrypt: out(r,c) = in(r,(c+s(r)) mod NB). Decrypt: out(r,(c+s(r)) mod NB) = in(r,c).
//  - The permutation is combinational on in_data. The result is written into the buffer on accept.
//  - Accept  = in_valid & in_ready. Release = out_valid & out_ready.
//  - in_ready = (occupancy != 2), derived from registered count only.
//    It has no combinational path from out_ready.
//  - Buffer is a 2-entry FIFO: head entry drives out_data/out_tag; out_valid = (occupancy != 0).
//  - Latency: a beat accepted at edge N is visible at the output after edge N, if the buffer was empty.
//  - Throughput: 1 beat/cycle while out_ready is held high.
//  - Occupancy 0: accept only, count 0->1.
//  - Occupancy 1: simultaneous accept and release keeps count at 1.
//    The new beat becomes head the next cycle.
//  - Occupancy 2: in_ready = 0. Release only, count 2->1.
//  - out_data/out_tag are held stable while out_valid=1 and out_ready=0.
//  - Beat order is strictly preserved. Mode, bypass and tag are per beat; no cross-beat state.
//  - Accept when in_valid=0 cannot occur. Inputs are ignored when accept is low.
//  - Reset (async assert, sync deassert by the top level) clears all state and discards buffered beats:
//    occupancy=0, out_valid=0, out_data=0, out_tag=0, in_ready=1.
//  - Reset mid-stream: in-flight beats are dropped and are not output after release.
// TESTING
//  1 NB=4 enc, in_data=d42711aee0bf98f1b8b45de51e415230 tag=3, out_ready=1
//    -> next cycle out_data=d4bf5d30e0b452aeb84111f11e2798e5, out_tag=3.
//  2 NB=4 dec, in_data=d4bf5d30e0b452aeb84111f11e2798e5
//    -> out_data=d42711aee0bf98f1b8b45de51e415230. Also: in_bypass=1 -> output equals input.
//  3 NB=4 enc, in_data=000102030405060708090a0b0c0d0e0f
//    -> 00050a0f04090e03080d02070c01060b.
//    NB=8 enc, bytes 00..1f -> first column 00050e13.
//  4 Backpressure: out_ready=0, send 3 beats tags 1,2,3
//    -> in_ready drops after 2 accepts, occupancy=2, out_tag holds 1.
//    Raise out_ready -> tags 1,2,3 emerge in order, one per cycle.
//  5 Occupancy 1 with in_valid=1 and out_ready=1 for 8 cycles
//    -> occupancy stays 1, 8 beats out, no bubble.
//  6 Assert rst with occupancy=2 -> out_valid=0, occupancy=0, in_ready=1 immediately.
//    The old beats never appear after release.

Source files
------------

// File: rtl/aes_shift_rows_pipe_if.sv
// Beat-level bus for the ShiftRows stage: upstream valid/ready beat plus downstream output.
// The master modport is the side that drives beats in and consumes them out (pipeline neighbour or bench).
// The slave modport is the stage itself.
interface aes_shift_rows_pipe_if #(
  parameter int NB        = 4,
  parameter int TAG_WIDTH = 4
);
  localparam int DATA_WIDTH = 32 * NB;

  logic                  in_valid;
  logic                  in_ready;
  logic                  in_decrypt;
  logic                  in_bypass;
  logic [DATA_WIDTH-1:0] in_data;
  logic [TAG_WIDTH-1:0]  in_tag;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [TAG_WIDTH-1:0]  out_tag;
  logic [1:0]            occupancy;

  modport master (
    output in_valid, in_decrypt, in_bypass, in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, occupancy
  );

  modport slave (
    input  in_valid, in_decrypt, in_bypass, in_data, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, occupancy
  );
endinterface

// File: rtl/aes_shift_rows_pipe.sv
// ShiftRows / InvShiftRows for Rijndael Nb = 4, 6, 8 with per-beat mode, bypass and tag.
// Latency: beat accepted at edge N is on the output right after edge N (buffer empty).
// Backpressure: 2-entry output buffer; in_ready depends only on the registered count.
module aes_shift_rows_pipe #(
  parameter int NB        = 4,
  parameter int TAG_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  aes_shift_rows_pipe_if.slave   bus
);
  localparam int DATA_WIDTH = 32 * NB;

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("aes_shift_rows_pipe: NB must be 4, 6 or 8");
  end

  // Row r rotates by r, except Nb=8 where rows 2 and 3 rotate by 3 and 4.
  function automatic int row_shift(input int r);
    return (NB == 8 && r >= 2) ? r + 1 : r;
  endfunction

  logic [DATA_WIDTH-1:0] perm;
  logic [DATA_WIDTH-1:0] head_data;
  logic [DATA_WIDTH-1:0] tail_data;
  logic [TAG_WIDTH-1:0]  head_tag;
  logic [TAG_WIDTH-1:0]  tail_tag;
  logic [1:0]            count;
  logic                  acc;
  logic                  rel;
  int                    sc;

  assign bus.in_ready  = (count != 2'd2);
  assign bus.out_valid = (count != 2'd0);
  assign bus.occupancy = count;
  assign bus.out_data  = head_data;
  assign bus.out_tag   = head_tag;

  assign acc = bus.in_valid & bus.in_ready;
  assign rel = bus.out_valid & bus.out_ready;

  // Byte permutation of the incoming state; encrypt gathers, decrypt scatters the same mapping.
  always_comb begin
    perm = bus.in_data;
    sc   = 0;
    if (!bus.in_bypass) begin
      for (int c = 0; c < NB; c++) begin
        for (int r = 0; r < 4; r++) begin
          sc = (c + row_shift(r)) % NB;
          if (bus.in_decrypt)
            perm[DATA_WIDTH-1-8*(4*sc+r) -: 8] = bus.in_data[DATA_WIDTH-1-8*(4*c+r) -: 8];
          else
            perm[DATA_WIDTH-1-8*(4*c+r) -: 8] = bus.in_data[DATA_WIDTH-1-8*(4*sc+r) -: 8];
        end
      end
    end
  end

  // Two-slot buffer: head drives the output, tail holds the second beat while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_data <= '0;
      head_tag  <= '0;
      tail_data <= '0;
      tail_tag  <= '0;
    end else if (acc && (count == 2'd0 || (count == 2'd1 && rel))) begin
      head_data <= perm;
      head_tag  <= bus.in_tag;
    end else if (acc) begin
      tail_data <= perm;
      tail_tag  <= bus.in_tag;
    end else if (rel && count == 2'd2) begin
      head_data <= tail_data;
      head_tag  <= tail_tag;
    end
  end

  // Occupancy tracks accepts minus releases; accept and release together leave it unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= 2'd0;
    end else begin
      case ({acc, rel})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_shift_rows_pipe.sv
// Directed bench for aes_shift_rows_pipe: NB=4 instance under full scoreboard, NB=8 instance for the wide case.
// Expected beats are computed by an independent byte-index model and queued at accept.
// Every cycle also checks occupancy/in_ready/out_valid against the scoreboard depth.
module tb_aes_shift_rows_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   rel_cnt = 0;
  int   rel_base;
  bit   last_acc;
  logic [255:0] qd[$];
  logic [3:0]   qt[$];
  logic [255:0] d8;

  aes_shift_rows_pipe_if #(.NB(4), .TAG_WIDTH(4)) bus4 ();
  aes_shift_rows_pipe_if #(.NB(8), .TAG_WIDTH(4)) bus8 ();

  aes_shift_rows_pipe #(.NB(4), .TAG_WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  aes_shift_rows_pipe #(.NB(8), .TAG_WIDTH(4)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));

  always #5 clk = ~clk;

  // Reference: output byte (row,col) taken from input column col+s (encrypt) or col-s (decrypt).
  function automatic logic [255:0] ref_shift(int nb, logic [255:0] din, bit dec, bit byp);
    logic [255:0] r;
    int w, row, col, sh, src;
    r = din;
    if (byp) return din;
    w = 32 * nb;
    for (int k = 0; k < 4 * nb; k++) begin
      row = k % 4;
      col = k / 4;
      sh  = (nb == 8 && row >= 2) ? row + 1 : row;
      src = dec ? (col - sh + nb) % nb : (col + sh) % nb;
      r[w-1-8*k -: 8] = din[w-1-8*(4*src+row) -: 8];
    end
    return r;
  endfunction

  task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check flags, score any release, queue any accept, then advance.
  task automatic step();
    bit acc, rel;
    @(negedge clk);
    chk("occupancy", 256'(bus4.occupancy), 256'(qd.size()));
    chk("in_ready", 256'(bus4.in_ready), 256'(qd.size() != 2));
    chk("out_valid", 256'(bus4.out_valid), 256'(qd.size() != 0));
    acc = bus4.in_valid && bus4.in_ready;
    rel = bus4.out_valid && bus4.out_ready;
    if (rel && qd.size() != 0) begin
      chk("out_data", 256'(bus4.out_data), qd.pop_front());
      chk("out_tag", 256'(bus4.out_tag), 256'(qt.pop_front()));
      rel_cnt++;
    end
    if (acc) begin
      qd.push_back(ref_shift(4, 256'(bus4.in_data), bus4.in_decrypt, bus4.in_bypass));
      qt.push_back(bus4.in_tag);
    end
    last_acc = acc;
    @(posedge clk);
    #1;
  endtask

  // Present a beat and hold it until accepted; in_valid stays high afterwards.
  task automatic send(logic [127:0] d, logic [3:0] t, bit dec, bit byp);
    bus4.in_valid   = 1'b1;
    bus4.in_data    = d;
    bus4.in_tag     = t;
    bus4.in_decrypt = dec;
    bus4.in_bypass  = byp;
    for (int i = 0; i < 20; i++) begin
      step();
      if (last_acc) return;
    end
    checks++;
    errors++;
    $error("FAIL send_timeout observed=no_accept expected=accept tag=%0d", t);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    bus4.in_valid = 0; bus4.in_decrypt = 0; bus4.in_bypass = 0;
    bus4.in_data = '0; bus4.in_tag = '0; bus4.out_ready = 1;
    bus8.in_valid = 0; bus8.in_decrypt = 0; bus8.in_bypass = 0;
    bus8.in_data = '0; bus8.in_tag = '0; bus8.out_ready = 1;

    // Reset state
    #1 rst = 1'b0;
    #1;
    chk("rst_occupancy", 256'(bus4.occupancy), 256'(0));
    chk("rst_out_valid", 256'(bus4.out_valid), 256'(0));
    chk("rst_out_data", 256'(bus4.out_data), 256'(0));
    chk("rst_out_tag", 256'(bus4.out_tag), 256'(0));
    chk("rst_in_ready", 256'(bus4.in_ready), 256'(1));
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // Known FIPS-197 encrypt vector, visible right after the accepting edge
    send(128'hd42711aee0bf98f1b8b45de51e415230, 4'd3, 1'b0, 1'b0);
    chk("enc_vec_data", 256'(bus4.out_data), 256'(128'hd4bf5d30e0b452aeb84111f11e2798e5));
    chk("enc_vec_tag", 256'(bus4.out_tag), 256'(4'd3));

    // Decrypt vector and bypass
    send(128'hd4bf5d30e0b452aeb84111f11e2798e5, 4'd5, 1'b1, 1'b0);
    chk("dec_vec_data", 256'(bus4.out_data), 256'(128'hd42711aee0bf98f1b8b45de51e415230));
    send(128'h0123456789abcdeffedcba9876543210, 4'd6, 1'b1, 1'b1);
    chk("bypass_data", 256'(bus4.out_data), 256'(128'h0123456789abcdeffedcba9876543210));

    // Counting-byte pattern on NB=4 and NB=8 together
    for (int k = 0; k < 32; k++) d8[255-8*k -: 8] = 8'(k);
    bus8.in_valid = 1'b1;
    bus8.in_data  = d8;
    bus8.in_tag   = 4'd9;
    send(128'h000102030405060708090a0b0c0d0e0f, 4'd7, 1'b0, 1'b0);
    chk("enc_count_data", 256'(bus4.out_data), 256'(128'h00050a0f04090e03080d02070c01060b));
    chk("nb8_out_valid", 256'(bus8.out_valid), 256'(1));
    chk("nb8_col0", 256'(bus8.out_data[255:224]), 256'(32'h00050e13));
    chk("nb8_full", 256'(bus8.out_data), ref_shift(8, d8, 1'b0, 1'b0));
    chk("nb8_tag", 256'(bus8.out_tag), 256'(4'd9));
    bus8.in_valid = 1'b0;
    bus4.in_valid = 1'b0;
    step();
    step();

    // Backpressure: two beats fill the buffer, the third waits
    bus4.out_ready = 1'b0;
    send(rnd128(), 4'd1, 1'b0, 1'b0);
    send(rnd128(), 4'd2, 1'b1, 1'b0);
    bus4.in_data = rnd128();
    bus4.in_tag  = 4'd3;
    for (int i = 0; i < 3; i++) step();
    chk("bp_in_ready", 256'(bus4.in_ready), 256'(0));
    chk("bp_occupancy", 256'(bus4.occupancy), 256'(2));
    chk("bp_head_tag", 256'(bus4.out_tag), 256'(1));
    bus4.out_ready = 1'b1;
    rel_base = rel_cnt;
    send(bus4.in_data, 4'd3, 1'b0, 1'b0);
    bus4.in_valid = 1'b0;
    step();
    chk("bp_drain_releases", 256'(rel_cnt - rel_base), 256'(3));
    chk("bp_drain_empty", 256'(bus4.occupancy), 256'(0));

    // Steady state at occupancy 1: one in and one out per cycle, no bubble
    bus4.out_ready = 1'b0;
    send(rnd128(), 4'd0, 1'b0, 1'b0);
    bus4.out_ready = 1'b1;
    rel_base = rel_cnt;
    for (int i = 0; i < 8; i++) begin
      send(rnd128(), 4'(i + 8), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      chk("steady_occupancy", 256'(bus4.occupancy), 256'(1));
    end
    chk("steady_releases", 256'(rel_cnt - rel_base), 256'(8));
    bus4.in_valid = 1'b0;
    step();

    // Reset with a full buffer discards both beats
    bus4.out_ready = 1'b0;
    send(rnd128(), 4'd4, 1'b0, 1'b0);
    send(rnd128(), 4'd5, 1'b0, 1'b0);
    bus4.in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", 256'(bus4.out_valid), 256'(0));
    chk("mid_rst_occupancy", 256'(bus4.occupancy), 256'(0));
    chk("mid_rst_in_ready", 256'(bus4.in_ready), 256'(1));
    qd.delete();
    qt.delete();
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    bus4.out_ready = 1'b1;
    step();
    step();
    send(128'h000102030405060708090a0b0c0d0e0f, 4'd12, 1'b1, 1'b0);
    bus4.in_valid = 1'b0;
    for (int i = 0; i < 10 && qd.size() != 0; i++) step();
    chk("final_queue_empty", 256'(qd.size()), 256'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
